burst_pattern_gen: RTL and testbench
====================================

BURST_PATTERN_GEN -- requirements
Module: burst_pattern_gen

Interface
REQ-001 Parameter: CNT_W, 20, width of the on-length and period counters (covers 675000-cycle periods).
REQ-002 Parameter: NUM_W, 8, width of the burst-count input and the burst index.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 Port: stop  in  1  abort request; honoured in any non-IDLE state.
REQ-007 Port: mode  in  1  0 = continuous, 1 = one-shot.
REQ-008 Port: on_len  in  CNT_W  high cycles per period.
REQ-009 Port: period_len  in  CNT_W  total cycles per period.
REQ-010 Port: burst_num  in  NUM_W  periods per run in one-shot mode.
REQ-011 Port: burst_out  out  1  registered burst waveform.
REQ-012 Port: busy  out  1  high while in ON or OFF.
REQ-013 Port: done  out  1  one-cycle pulse when a one-shot run completes.
REQ-014 Port: cfg_err  out  1  one-cycle pulse when a start is rejected.
REQ-015 Port: burst_idx  out  NUM_W  count of completed periods in the current run.

Function
REQ-016 FSM states SHALL be IDLE, ON and OFF; busy SHALL be 1 exactly in ON/OFF.
REQ-017 On start in IDLE, mode/on_len/period_len/burst_num SHALL be latched; input changes during a run SHALL have no effect.
REQ-018 A start with period_len==0, or with mode==1 and burst_num==0, SHALL be rejected: cfg_err pulses the next cycle and the FSM stays in IDLE.
REQ-019 On an accepted start at edge T, the FSM SHALL enter ON (or OFF if on_len==0), with the period counter at 0 and burst_out valid from cycle T+1.
REQ-020 burst_out SHALL be 1 for the first min(on_len, period_len) cycles of each period and 0 for the rest; on_len>=period_len gives constant 1.
REQ-021 Transition ON->OFF SHALL occur when the counter reaches on_len-1 and on_len<period_len.
REQ-022 At counter==period_len-1, the counter SHALL wrap to 0 and burst_idx SHALL increment; the next state is ON if on_len>0, else OFF.
REQ-023 In continuous mode, burst_idx SHALL wrap modulo 2^NUM_W and the run SHALL continue indefinitely.
REQ-024 In one-shot mode, when the period ending makes burst_idx==burst_num, the FSM SHALL go to IDLE: next cycle burst_out=0, busy=0, done=1 for one cycle.
REQ-025 stop SHALL have priority over all other events: at the next edge the FSM goes to IDLE and burst_out=0, with no done pulse and burst_idx held.
REQ-026 start while busy SHALL be ignored; start and stop together in IDLE SHALL be ignored.
REQ-027 burst_idx SHALL clear to 0 on an accepted start.

Reset
REQ-028 While rst_n=0: state=IDLE, counter=0, burst_idx=0, and burst_out=busy=done=cfg_err=0, all asynchronously.
REQ-029 Reset asserted mid-run SHALL abort the run without a done pulse; after release the block waits for a new start.

Structure
REQ-030 The shared package SHALL hold the state enum (IDLE/ON/OFF), the mode encoding constants and the legacy defaults ON=450000, PERIOD=675000.
REQ-031 One sub-module, burst_period_counter (CNT_W-wide counter with load, wrap and terminal-count flags), SHALL be used; the FSM SHALL stay in the top module.

Verification (CNT_W=8, NUM_W=4)
REQ-032 One-shot: on_len=3, period_len=5, burst_num=2 -> burst_out 1110011100, then done=1 for one cycle, busy=0, burst_idx=2.
REQ-033 Continuous: on_len=2, period_len=4 for 20 periods -> pattern 1100 repeats, with burst_idx wrapping 15->0.
REQ-034 Edge lengths: on_len=0 gives constant 0 with busy=1; on_len=6 with period_len=4 gives constant 1.
REQ-035 Rejects: start with period_len=0, then one-shot start with burst_num=0 -> a one-cycle cfg_err each time, busy stays 0.
REQ-036 Abort: stop in cycle 2 of period 2 -> burst_out=0 and busy=0 next cycle, no done; rst_n low mid-run gives all outputs 0 immediately.

Source files
------------

// File: rtl/burst_pattern_gen_pkg.sv
// rtl/burst_pattern_gen_pkg.sv - shared types and constants for the burst pattern generator
package burst_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic MODE_CONTINUOUS = 1'b0;
    localparam logic MODE_ONE_SHOT   = 1'b1;

    // Legacy waveform defaults the block was originally tuned for.
    localparam int unsigned DEFAULT_ON_LEN     = 450000;
    localparam int unsigned DEFAULT_PERIOD_LEN = 675000;

endpackage

// File: rtl/burst_period_counter.sv
// rtl/burst_period_counter.sv - period counter with clear, wrap and terminal-count flags
module burst_period_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_on_len,
    input  logic [CNT_W-1:0] i_period_len,
    output logic             o_on_end,
    output logic             o_period_end
);

    logic [CNT_W-1:0] r_count;

    // A zero on-length has no last ON cycle, so the flag must never fire.
    assign o_on_end     = (i_on_len != '0) && (r_count == i_on_len - CNT_W'(1));
    assign o_period_end = (r_count == i_period_len - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_period_end ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/burst_pattern_gen.sv
// rtl/burst_pattern_gen.sv - configurable on/off burst waveform generator (continuous or one-shot)
module burst_pattern_gen
    import burst_pattern_gen_pkg::*;
#(
    parameter int CNT_W = 20,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] on_len,
    input  logic [CNT_W-1:0] period_len,
    input  logic [NUM_W-1:0] burst_num,
    output logic             burst_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [NUM_W-1:0] burst_idx
);

    state_t           r_state;
    logic             r_mode;
    logic [CNT_W-1:0] r_on_len;
    logic [CNT_W-1:0] r_period_len;
    logic [NUM_W-1:0] r_burst_num;
    logic             r_burst_out;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;
    logic [NUM_W-1:0] r_burst_idx;

    logic             w_run;
    logic             w_on_end;
    logic             w_period_end;
    logic             w_on_short;
    logic [NUM_W-1:0] w_idx_next;

    assign w_run      = (r_state != ST_IDLE);
    assign w_on_short = (r_on_len < r_period_len);
    assign w_idx_next = r_burst_idx + NUM_W'(1);

    // Held at zero while idle so every accepted run begins its first period at count 0.
    burst_period_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (~w_run),
        .i_en         (w_run),
        .i_on_len     (r_on_len),
        .i_period_len (r_period_len),
        .o_on_end     (w_on_end),
        .o_period_end (w_period_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_CONTINUOUS;
            r_on_len     <= '0;
            r_period_len <= '0;
            r_burst_num  <= '0;
            r_burst_out  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_burst_idx  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (period_len == '0 || (mode == MODE_ONE_SHOT && burst_num == '0)) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_mode       <= mode;
                            r_on_len     <= on_len;
                            r_period_len <= period_len;
                            r_burst_num  <= burst_num;
                            r_burst_idx  <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= (on_len != '0) ? ST_ON : ST_OFF;
                            r_burst_out  <= (on_len != '0);
                        end
                    end
                end
                ST_ON, ST_OFF: begin
                    if (stop) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_burst_out <= 1'b0;
                    end else if (w_period_end) begin
                        r_burst_idx <= w_idx_next;
                        if (r_mode == MODE_ONE_SHOT && w_idx_next == r_burst_num) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_burst_out <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_state     <= (r_on_len != '0) ? ST_ON : ST_OFF;
                            r_burst_out <= (r_on_len != '0);
                        end
                    end else if (r_state == ST_ON && w_on_end && w_on_short) begin
                        r_state     <= ST_OFF;
                        r_burst_out <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_burst_out <= 1'b0;
                end
            endcase
        end
    end

    assign burst_out = r_burst_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign burst_idx = r_burst_idx;

endmodule

// File: tb/tb_burst_pattern_gen.sv
// tb/tb_burst_pattern_gen.sv - randomized self-checking bench for burst_pattern_gen
module tb_burst_pattern_gen;

    localparam int CNT_W = 8;
    localparam int NUM_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             mode = 1'b0;
    logic [CNT_W-1:0] on_len = '0;
    logic [CNT_W-1:0] period_len = '0;
    logic [NUM_W-1:0] burst_num = '0;
    logic             burst_out;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [NUM_W-1:0] burst_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    burst_pattern_gen #(
        .CNT_W(CNT_W),
        .NUM_W(NUM_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .on_len     (on_len),
        .period_len (period_len),
        .burst_num  (burst_num),
        .burst_out  (burst_out),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .burst_idx  (burst_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int exp_idx, input logic exp_done);
        check({tag, " burst_out"}, burst_out, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, exp_done);
        check({tag, " cfg_err"}, cfg_err, 0);
        check({tag, " burst_idx"}, burst_idx, exp_idx);
    endtask

    // Expected waveform derives only from elapsed cycles k since the start edge.
    task automatic run_cfg(input logic m, input int on, input int per, input int num,
                           input int stop_at, input logic scramble);
        int total;
        int c;
        int p;
        total = num * per;
        mode = m;
        on_len = CNT_W'(on);
        period_len = CNT_W'(per);
        burst_num = NUM_W'(num);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            p = k / per;
            c = k % per;
            if (m && k == total) begin
                start = 1'b0;
                check_idle("complete", num % 16, 1'b1);
                step();
                check_idle("after done", num % 16, 1'b0);
                return;
            end
            check("run burst_out", burst_out, (c < on) ? 1 : 0);
            check("run busy", busy, 1);
            check("run done", done, 0);
            check("run burst_idx", burst_idx, p % 16);
            if (k == stop_at) begin
                start = 1'b0;
                stop = 1'b1;
                step();
                stop = 1'b0;
                check_idle("abort", p % 16, 1'b0);
                step();
                check_idle("abort settled", p % 16, 1'b0);
                return;
            end
            if (scramble) begin
                mode = 1'($urandom);
                on_len = CNT_W'($urandom);
                period_len = CNT_W'($urandom);
                burst_num = NUM_W'($urandom);
                start = 1'($urandom);
            end
            step();
        end
        check("run bound expired", 1, 0);
    endtask

    task automatic reject(input logic m, input int per, input int num);
        mode = m;
        on_len = 8'd2;
        period_len = CNT_W'(per);
        burst_num = NUM_W'(num);
        start = 1'b1;
        step();
        start = 1'b0;
        check("reject cfg_err", cfg_err, 1);
        check("reject busy", busy, 0);
        step();
        check("reject cfg_err clears", cfg_err, 0);
        check("reject busy stays", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int m;
        int per;
        int on;
        int num;
        int stop_at;

        #2;
        check_idle("reset", 0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_idle("post reset", 0, 1'b0);

        run_cfg(1'b1, 3, 5, 2, -1, 1'b0);
        run_cfg(1'b0, 2, 4, 0, 80, 1'b1);
        run_cfg(1'b0, 0, 3, 0, 10, 1'b1);
        run_cfg(1'b0, 6, 4, 0, 12, 1'b1);
        reject(1'b0, 0, 3);
        reject(1'b1, 5, 0);
        run_cfg(1'b0, 3, 5, 0, 7, 1'b0);
        run_cfg(1'b1, 3, 5, 3, 7, 1'b0);

        mode = 1'b0;
        period_len = 8'd4;
        on_len = 8'd2;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("start+stop busy", busy, 0);
        check("start+stop cfg_err", cfg_err, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre-reset busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async reset", 0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check_idle("after reset release", 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            m = int'($urandom_range(0, 1));
            per = int'($urandom_range(1, 9));
            on = int'($urandom_range(0, 11));
            num = int'($urandom_range(1, 5));
            if (m == 1)
                stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, num * per - 1)) : -1;
            else
                stop_at = int'($urandom_range(0, 40));
            run_cfg(1'(m), on, per, num, stop_at, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
